// File: rtl/scalar_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : scalar_issue_ctrl
// Purpose  : Issue sequencer for the scalar lane. Pulls instructions from
//            IQ0, drives the scalar decoder and issues ALU ops to execute.
//            BRANCH, LOOP, HALT, YIELD and NOP are resolved here. Owns the
//            loop counter, the compare-flag interlock, the redirect/flush
//            request to fetch, and the halt/yield/fault status.
// Ports    : clk, rst_n            - clock, async active-low reset
//            start_i, resume_i     - run-control pulses
//            iq_valid_i/iq_instr_i/iq_ready_o  - IQ0 handshake
//            dec_instr_o           - pass-through to scalar decoder
//            dec_op_i/dec_illegal_i/dec_imm_i  - decoder results
//            ex_valid_o/ex_ready_i - ALU issue handshake
//            cmp_done_i/cmp_flag_i - CMP completion
//            lc_done_i/lc_value_i  - LCSET completion
//            redir_valid_o/redir_offs_o - redirect pulse to fetch
//            busy_o/halted_o/yielded_o/fault_o - status
// Revision : 1.0 - initial release
// ============================================================================
module scalar_issue_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int LC_WIDTH   = 16,
  parameter int OFFS_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  resume_i,
  input  logic                  iq_valid_i,
  input  logic [31:0]           iq_instr_i,
  output logic                  iq_ready_o,
  output logic [31:0]           dec_instr_o,
  input  logic [5:0]            dec_op_i,
  input  logic                  dec_illegal_i,
  input  logic [DATA_WIDTH-1:0] dec_imm_i,
  output logic                  ex_valid_o,
  input  logic                  ex_ready_i,
  input  logic                  cmp_done_i,
  input  logic                  cmp_flag_i,
  input  logic                  lc_done_i,
  input  logic [LC_WIDTH-1:0]   lc_value_i,
  output logic                  redir_valid_o,
  output logic [OFFS_WIDTH-1:0] redir_offs_o,
  output logic                  busy_o,
  output logic                  halted_o,
  output logic                  yielded_o,
  output logic                  fault_o
);

  // op_t encoding produced by the scalar decoder
  localparam logic [5:0] OP_ADD_IMM   = 6'd0;
  localparam logic [5:0] OP_ADD_REG   = 6'd1;
  localparam logic [5:0] OP_SUB_IMM   = 6'd2;
  localparam logic [5:0] OP_SUB_REG   = 6'd3;
  localparam logic [5:0] OP_SHL_IMM   = 6'd4;
  localparam logic [5:0] OP_SHL_REG   = 6'd5;
  localparam logic [5:0] OP_SHR_IMM   = 6'd6;
  localparam logic [5:0] OP_SHR_REG   = 6'd7;
  localparam logic [5:0] OP_MOV_IMM   = 6'd8;
  localparam logic [5:0] OP_MOV_REG   = 6'd9;
  localparam logic [5:0] OP_CMP_IMM   = 6'd10;
  localparam logic [5:0] OP_CMP_REG   = 6'd11;
  localparam logic [5:0] OP_LCSET_IMM = 6'd12;
  localparam logic [5:0] OP_LCSET_REG = 6'd13;
  localparam logic [5:0] OP_BRANCH    = 6'd16;
  localparam logic [5:0] OP_LOOP      = 6'd17;
  localparam logic [5:0] OP_HALT      = 6'd18;
  localparam logic [5:0] OP_YIELD     = 6'd19;
  localparam logic [5:0] OP_NOP       = 6'd20;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_FLUSH   = 3'd2,
    S_YIELDED = 3'd3,
    S_HALTED  = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic                  flag_q, flag_d;
  logic [LC_WIDTH-1:0]   lc_q, lc_d;
  logic                  cmp_pend_q, cmp_pend_d;
  logic                  lc_pend_q, lc_pend_d;

  logic                  cmp_issue;
  logic                  lc_issue;
  logic                  lc_dec;

  // Only the low OFFS_WIDTH immediate bits form a PC offset.
  logic                  unused_imm_hi;
  assign unused_imm_hi = ^dec_imm_i[DATA_WIDTH-1:OFFS_WIDTH];

  assign dec_instr_o = iq_instr_i;

  // --------------------------------------------------------------------------
  // Next-state and issue logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    iq_ready_o    = 1'b0;
    ex_valid_o    = 1'b0;
    redir_valid_o = 1'b0;
    redir_offs_o  = '0;
    cmp_issue     = 1'b0;
    lc_issue      = 1'b0;
    lc_dec        = 1'b0;

    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start_i) state_d = S_RUN;
      end
      S_YIELDED: begin
        if (resume_i) state_d = S_RUN;
      end
      S_FLUSH: begin
        // One dead cycle lets fetch drop wrong-path IQ entries.
        state_d = S_RUN;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      S_RUN: begin
        if (iq_valid_i) begin
          if (dec_illegal_i) begin
            // Illegal instruction stays in IQ0 for post-mortem inspection.
            state_d = S_FAULT;
          end else begin
            case (dec_op_i)
              OP_ADD_IMM, OP_ADD_REG, OP_SUB_IMM, OP_SUB_REG,
              OP_SHL_IMM, OP_SHL_REG, OP_SHR_IMM, OP_SHR_REG,
              OP_MOV_IMM, OP_MOV_REG, OP_CMP_IMM, OP_CMP_REG,
              OP_LCSET_IMM, OP_LCSET_REG: begin
                ex_valid_o = 1'b1;
                iq_ready_o = ex_ready_i;
                cmp_issue  = ex_ready_i &&
                             (dec_op_i == OP_CMP_IMM || dec_op_i == OP_CMP_REG);
                lc_issue   = ex_ready_i &&
                             (dec_op_i == OP_LCSET_IMM || dec_op_i == OP_LCSET_REG);
              end
              OP_BRANCH: begin
                if (!cmp_pend_q) begin
                  iq_ready_o = 1'b1;
                  if (flag_q) begin
                    redir_valid_o = 1'b1;
                    redir_offs_o  = dec_imm_i[OFFS_WIDTH-1:0];
                    state_d       = S_FLUSH;
                  end
                end
              end
              OP_LOOP: begin
                if (!lc_pend_q) begin
                  iq_ready_o = 1'b1;
                  // lc==0 falls through, so the counter never wraps.
                  if (lc_q != '0) begin
                    lc_dec        = 1'b1;
                    redir_valid_o = 1'b1;
                    redir_offs_o  = dec_imm_i[OFFS_WIDTH-1:0];
                    state_d       = S_FLUSH;
                  end
                end
              end
              OP_HALT: begin
                if (!cmp_pend_q && !lc_pend_q) begin
                  iq_ready_o = 1'b1;
                  state_d    = S_HALTED;
                end
              end
              OP_YIELD: begin
                if (!cmp_pend_q && !lc_pend_q) begin
                  iq_ready_o = 1'b1;
                  state_d    = S_YIELDED;
                end
              end
              default: begin
                // NOP and any other legal-but-unhandled op: consume, no effect.
                iq_ready_o = 1'b1;
              end
            endcase
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Interlock state. Completions are honoured only while the matching pend
  // bit is set, so results still in flight across a reset are dropped.
  // A same-cycle completion + new issue leaves the pend bit set.
  // --------------------------------------------------------------------------
  always_comb begin
    flag_d     = flag_q;
    lc_d       = lc_q;
    cmp_pend_d = cmp_issue | (cmp_pend_q & ~cmp_done_i);
    lc_pend_d  = lc_issue  | (lc_pend_q  & ~lc_done_i);

    if (cmp_done_i && cmp_pend_q) flag_d = cmp_flag_i;

    if (lc_done_i && lc_pend_q) begin
      lc_d = lc_value_i;
    end else if (lc_dec) begin
      lc_d = lc_q - LC_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      flag_q     <= 1'b0;
      lc_q       <= '0;
      cmp_pend_q <= 1'b0;
      lc_pend_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      flag_q     <= flag_d;
      lc_q       <= lc_d;
      cmp_pend_q <= cmp_pend_d;
      lc_pend_q  <= lc_pend_d;
    end
  end

  assign busy_o    = (state_q == S_RUN) || (state_q == S_FLUSH);
  assign halted_o  = (state_q == S_HALTED);
  assign yielded_o = (state_q == S_YIELDED);
  assign fault_o   = (state_q == S_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_scalar_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_scalar_issue_ctrl
// Purpose  : Self-checking bench for scalar_issue_ctrl. The bench plays the
//            decoder (drives dec_op/dec_imm directly) and a simple execute
//            unit that returns CMP/LCSET completions a set number of cycles
//            after their issue handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scalar_issue_ctrl;

  localparam int DW  = 32;
  localparam int LCW = 16;
  localparam int OW  = 18;

  // Decoder op_t encoding
  localparam logic [5:0] OP_ADD_IMM   = 6'd0;
  localparam logic [5:0] OP_SUB_REG   = 6'd3;
  localparam logic [5:0] OP_CMP_IMM   = 6'd10;
  localparam logic [5:0] OP_CMP_REG   = 6'd11;
  localparam logic [5:0] OP_LCSET_IMM = 6'd12;
  localparam logic [5:0] OP_LCSET_REG = 6'd13;
  localparam logic [5:0] OP_BRANCH    = 6'd16;
  localparam logic [5:0] OP_LOOP      = 6'd17;
  localparam logic [5:0] OP_HALT      = 6'd18;
  localparam logic [5:0] OP_YIELD     = 6'd19;
  localparam logic [5:0] OP_NOP       = 6'd20;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            resume = 1'b0;
  logic            iq_valid = 1'b0;
  logic [31:0]     iq_instr = 32'hDEAD_BEEF;
  logic            iq_ready;
  logic [31:0]     dec_instr;
  logic [5:0]      dec_op = OP_NOP;
  logic            dec_illegal = 1'b0;
  logic [DW-1:0]   dec_imm = '0;
  logic            ex_valid;
  logic            ex_ready = 1'b1;
  logic            cmp_done = 1'b0;
  logic            cmp_flag = 1'b0;
  logic            lc_done = 1'b0;
  logic [LCW-1:0]  lc_value = '0;
  logic            redir_valid;
  logic [OW-1:0]   redir_offs;
  logic            busy, halted, yielded, fault;

  always #5 clk = ~clk;

  scalar_issue_ctrl #(.DATA_WIDTH(DW), .LC_WIDTH(LCW), .OFFS_WIDTH(OW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .resume_i     (resume),
    .iq_valid_i   (iq_valid),
    .iq_instr_i   (iq_instr),
    .iq_ready_o   (iq_ready),
    .dec_instr_o  (dec_instr),
    .dec_op_i     (dec_op),
    .dec_illegal_i(dec_illegal),
    .dec_imm_i    (dec_imm),
    .ex_valid_o   (ex_valid),
    .ex_ready_i   (ex_ready),
    .cmp_done_i   (cmp_done),
    .cmp_flag_i   (cmp_flag),
    .lc_done_i    (lc_done),
    .lc_value_i   (lc_value),
    .redir_valid_o(redir_valid),
    .redir_offs_o (redir_offs),
    .busy_o       (busy),
    .halted_o     (halted),
    .yielded_o    (yielded),
    .fault_o      (fault)
  );

  // Expected effect of one consumed instruction
  typedef struct {
    logic          ex;
    logic          redir;
    logic [OW-1:0] offs;
  } exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Execute-unit model configuration
  int             cmp_lat = 3;
  int             lc_lat  = 1;
  logic           cmp_flag_cfg = 1'b1;
  logic [LCW-1:0] lc_val_cfg = 16'd2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Execute model: completion pulse lands cmp_lat/lc_lat cycles after the
  // issue handshake, driven on the falling edge.
  initial begin
    int cmp_timer;
    int lc_timer;
    cmp_timer = 0;
    lc_timer  = 0;
    forever begin
      @(negedge clk);
      cmp_done = 1'b0;
      lc_done  = 1'b0;
      if (cmp_timer > 0) begin
        cmp_timer--;
        if (cmp_timer == 0) begin
          cmp_done = 1'b1;
          cmp_flag = cmp_flag_cfg;
        end
      end
      if (lc_timer > 0) begin
        lc_timer--;
        if (lc_timer == 0) begin
          lc_done  = 1'b1;
          lc_value = lc_val_cfg;
        end
      end
      if (ex_valid && ex_ready && (dec_op == OP_CMP_IMM || dec_op == OP_CMP_REG))
        cmp_timer = cmp_lat;
      if (ex_valid && ex_ready && (dec_op == OP_LCSET_IMM || dec_op == OP_LCSET_REG))
        lc_timer = lc_lat;
    end
  end

  // Present one instruction (called just after a rising edge); returns the
  // number of stall cycles before it was consumed.
  task automatic present(input string tag, input logic [5:0] op, input logic [DW-1:0] imm,
                         input logic e_ex, input logic e_redir, input int max_wait,
                         output int waited);
    exp_t e;
    logic done;
    e.ex    = e_ex;
    e.redir = e_redir;
    e.offs  = e_redir ? imm[OW-1:0] : '0;
    sb_q.push_back(e);
    iq_valid = 1'b1;
    dec_op   = op;
    dec_imm  = imm;
    iq_instr = $urandom;
    waited   = 0;
    done     = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (iq_ready) begin
        e = sb_q.pop_front();
        check({tag, ".ex_valid"},    {31'd0, ex_valid},    {31'd0, e.ex});
        check({tag, ".redir_valid"}, {31'd0, redir_valid}, {31'd0, e.redir});
        check({tag, ".redir_offs"},  {14'd0, redir_offs},  {14'd0, e.offs});
        done = 1'b1;
      end else if (waited == max_wait) begin
        check({tag, ".consumed"}, {31'd0, iq_ready}, 32'd1);
        e = sb_q.pop_front();
        done = 1'b1;
      end else begin
        waited++;
      end
      @(posedge clk); #1;
    end
    iq_valid = 1'b0;
    dec_op   = OP_NOP;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int w;

    // ---------------- Reset state ----------------
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.iq_ready",    {31'd0, iq_ready},    32'd0);
    check("rst.ex_valid",    {31'd0, ex_valid},    32'd0);
    check("rst.redir_valid", {31'd0, redir_valid}, 32'd0);
    check("rst.redir_offs",  {14'd0, redir_offs},  32'd0);
    check("rst.busy",        {31'd0, busy},        32'd0);
    check("rst.halted",      {31'd0, halted},      32'd0);
    check("rst.yielded",     {31'd0, yielded},     32'd0);
    check("rst.fault",       {31'd0, fault},       32'd0);
    check("rst.dec_instr",   dec_instr,            32'hDEAD_BEEF);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("idle.busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    pulse_start();

    // ---------------- Back-to-back ALU/NOP ----------------
    present("add", OP_ADD_IMM, 32'd5, 1'b1, 1'b0, 4, w);
    check("add.stall", w, 0);
    present("sub", OP_SUB_REG, 32'd0, 1'b1, 1'b0, 4, w);
    check("sub.stall", w, 0);
    present("nop", OP_NOP, 32'd0, 1'b0, 1'b0, 4, w);
    check("nop.stall", w, 0);

    // ---------------- CMP -> BRANCH interlock ----------------
    cmp_lat = 3; cmp_flag_cfg = 1'b1;
    present("cmp", OP_CMP_IMM, 32'd7, 1'b1, 1'b0, 4, w);
    check("cmp.stall", w, 0);
    present("br", OP_BRANCH, 32'hFFFF_FFFC, 1'b0, 1'b1, 10, w);
    check("br.stall", w, 3);
    present("flush_nop", OP_NOP, 32'd0, 1'b0, 1'b0, 4, w);
    check("flush.stall", w, 1);

    // ---------------- LCSET -> LOOP x4 ----------------
    lc_lat = 1; lc_val_cfg = 16'd2;
    present("lcset", OP_LCSET_IMM, 32'd2, 1'b1, 1'b0, 4, w);
    check("lcset.stall", w, 0);
    present("loop1", OP_LOOP, 32'hFFFF_FFFE, 1'b0, 1'b1, 10, w);
    check("loop1.stall", w, 1);
    present("loop2", OP_LOOP, 32'hFFFF_FFFE, 1'b0, 1'b1, 10, w);
    check("loop2.stall", w, 1);
    present("loop3", OP_LOOP, 32'hFFFF_FFFE, 1'b0, 1'b0, 10, w);
    check("loop3.stall", w, 1);
    present("loop4", OP_LOOP, 32'hFFFF_FFFE, 1'b0, 1'b0, 10, w);
    check("loop4.stall", w, 0);

    // ---------------- YIELD / resume ----------------
    present("yield", OP_YIELD, 32'd0, 1'b0, 1'b0, 4, w);
    iq_valid = 1'b1; dec_op = OP_NOP;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("yld.yielded",  {31'd0, yielded},  32'd1);
      check("yld.busy",     {31'd0, busy},     32'd0);
      check("yld.iq_ready", {31'd0, iq_ready}, 32'd0);
      @(posedge clk); #1;
    end
    iq_valid = 1'b0;
    resume = 1'b1;
    @(posedge clk); #1;
    resume = 1'b0;
    @(negedge clk);
    check("resume.busy",    {31'd0, busy},    32'd1);
    check("resume.yielded", {31'd0, yielded}, 32'd0);
    @(posedge clk); #1;

    // ---------------- HALT / start, state retained ----------------
    present("halt", OP_HALT, 32'd0, 1'b0, 1'b0, 4, w);
    iq_valid = 1'b1; dec_op = OP_NOP;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hlt.halted",   {31'd0, halted},   32'd1);
      check("hlt.iq_ready", {31'd0, iq_ready}, 32'd0);
      @(posedge clk); #1;
    end
    iq_valid = 1'b0;
    pulse_start();
    // flag=1 retained -> taken; lc=0 retained -> loop falls through
    present("br_kept", OP_BRANCH, 32'd8, 1'b0, 1'b1, 4, w);
    present("nop2", OP_NOP, 32'd0, 1'b0, 1'b0, 4, w);
    present("loop_kept", OP_LOOP, 32'd4, 1'b0, 1'b0, 4, w);
    check("loop_kept.stall", w, 0);

    // ---------------- Illegal -> FAULT ----------------
    iq_valid = 1'b1; dec_op = OP_ADD_IMM; dec_illegal = 1'b1;
    @(negedge clk);
    check("ill.iq_ready", {31'd0, iq_ready}, 32'd0);
    @(posedge clk); #1;
    dec_illegal = 1'b0;
    @(negedge clk);
    check("flt.fault",    {31'd0, fault},    32'd1);
    check("flt.busy",     {31'd0, busy},     32'd0);
    check("flt.iq_ready", {31'd0, iq_ready}, 32'd0);
    check("flt.ex_valid", {31'd0, ex_valid}, 32'd0);
    @(posedge clk); #1;
    pulse_start();
    @(negedge clk);
    check("flt.start_ignored", {31'd0, fault}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    iq_valid = 1'b0;
    @(negedge clk);
    check("flt.rst_fault", {31'd0, fault}, 32'd0);
    check("flt.rst_busy",  {31'd0, busy},  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---------------- Reset mid-stall, late cmp_done ignored ----------------
    pulse_start();
    cmp_lat = 6; cmp_flag_cfg = 1'b1;
    present("cmp2", OP_CMP_REG, 32'd0, 1'b1, 1'b0, 4, w);
    iq_valid = 1'b1; dec_op = OP_BRANCH; dec_imm = 32'd12;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("stall2.iq_ready", {31'd0, iq_ready}, 32'd0);
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("rst2.iq_ready",    {31'd0, iq_ready},    32'd0);
    check("rst2.ex_valid",    {31'd0, ex_valid},    32'd0);
    check("rst2.redir_valid", {31'd0, redir_valid}, 32'd0);
    check("rst2.busy",        {31'd0, busy},        32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    iq_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    pulse_start();
    // pend bit was cleared by reset, so the stale result left flag at 0
    present("br_after_rst", OP_BRANCH, 32'd12, 1'b0, 1'b0, 4, w);
    check("br_after_rst.stall", w, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/scalar_issue_ctrl.md
Name: scalar_issue_ctrl

Overview:
- Sequences the scalar lane: pulls instructions from IQ0, drives the scalar decoder, and issues ALU ops to execute.
- Resolves control ops locally: BRANCH, LOOP, HALT, YIELD, NOP.
- Owns the loop counter, the compare-flag interlock, the redirect/flush request to fetch, and halt/yield/fault status.

Parameters:
- DATA_WIDTH, 32, scalar datapath width; must match qtpa_pkg.
- LC_WIDTH, 16, loop-counter width.
- OFFS_WIDTH, 18, branch/loop offset width, taken from imm18.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; leaves IDLE/HALTED.
- resume  in  1  one-cycle pulse; leaves YIELDED.
- iq_valid  in  1  IQ0 holds an instruction.
- iq_instr  in  32  IQ0 instruction.
- iq_ready  out  1  instruction consumed this cycle.
- dec_instr  out  32  to scalar decoder; equals iq_instr.
- dec_op  in  6  op_t from decoder.
- dec_illegal  in  1  decoder illegal flag.
- dec_imm  in  DATA_WIDTH  sign-extended immediate.
- ex_valid  out  1  issue ALU op.
- ex_ready  in  1  ALU accepts.
- cmp_done  in  1  CMP result valid.
- cmp_flag  in  1  CMP result; 1 means branch taken.
- lc_done  in  1  LCSET result valid.
- lc_value  in  LC_WIDTH  LCSET value.
- redir_valid  out  1  one-cycle redirect pulse.
- redir_offs  out  OFFS_WIDTH  signed PC offset.
- busy, halted, yielded, fault  out  1 each  status.

Behaviour:
- Reset state: IDLE; lc=0; flag=0; cmp_pend=0; lc_pend=0. All outputs 0 except dec_instr, which passes through.
- States: IDLE, RUN, FLUSH, YIELDED, HALTED, FAULT. busy=1 only in RUN or FLUSH. halted/yielded/fault are Moore outputs of their states.
- IDLE: on start, go to RUN. HALTED: on start, go to RUN; lc and flag are retained. YIELDED: on resume, go to RUN. FAULT: exits only on reset.
- RUN: instruction present when iq_valid=1. Decode is combinational in the same cycle.
  - ALU op (ADD/SUB/SHL/SHR/MOV/CMP/LCSET, _IMM or _REG):
    - ex_valid=1; iq_ready = ex_ready.
    - On handshake, CMP_* sets cmp_pend and LCSET_* sets lc_pend.
  - BRANCH:
    - Stall (iq_ready=0) while cmp_pend=1.
    - Otherwise iq_ready=1. If flag=1: redir_valid=1, redir_offs = dec_imm[OFFS_WIDTH-1:0], go to FLUSH. Else fall through.
  - LOOP:
    - Stall while lc_pend=1.
    - Otherwise iq_ready=1. If lc≠0: lc←lc−1, redirect as BRANCH, go to FLUSH. If lc=0: fall through; no wrap to all-ones.
  - NOP: iq_ready=1, no effect.
  - HALT: consume the instruction, go to HALTED. Wait for cmp_pend/lc_pend to clear first.
  - YIELD: consume the instruction, go to YIELDED. Wait for cmp_pend/lc_pend to clear first.
  - dec_illegal=1: iq_ready=0, go to FAULT. The instruction is not consumed.
- FLUSH: exactly one cycle with iq_ready=0, so fetch can discard wrong-path entries. Then RUN.
- cmp_done: flag←cmp_flag; cmp_pend←0. lc_done: lc←lc_value; lc_pend←0.
  - If a completion and a new CMP/LCSET issue land in the same cycle, the pend bit ends at 1 and the value updates from the completion.
  - Completions are accepted in every state.
- Latency: an unstalled ALU op with ex_ready=1 issues in the same cycle it is presented. Throughput is 1 instruction/cycle in RUN.
- No instruction is consumed outside RUN. ex_valid, redir_valid and iq_ready are 0 in every other state.
- Reset mid-operation: immediate return to reset values. In-flight completions after reset are ignored because the pend bits are cleared.

Test Plan:
- Reset, start, then ADD_IMM, SUB_REG, NOP back-to-back with ex_ready=1 -> 3 consecutive iq_ready cycles; ex_valid on 2 of them; no redirect.
- CMP_IMM, then BRANCH imm=-4 with cmp_done/cmp_flag=1 arriving 3 cycles later -> BRANCH stalls 3 cycles, then redir_valid=1 with redir_offs=0x3FFFC. FLUSH holds iq_ready=0 for 1 cycle.
- LCSET with lc_value=2, then LOOP imm=-2 presented 3 times -> redirect twice (lc 2→1→0); 3rd LOOP falls through; lc stays 0.
- YIELD, resume 5 cycles later, then HALT, then start -> yielded=1 for 5 cycles; RUN resumes; halted=1 until start; lc/flag preserved.
- Opcode with dec_illegal=1 -> fault=1, iq_ready=0 thereafter; start ignored; rst_n low clears to IDLE.
- rst_n asserted mid-stall with cmp_pend=1, then cmp_done after release -> all outputs 0 during reset; flag stays 0 after cmp_done.
